readout_rr_scheduler: RTL and testbench

// Round-robin readout scheduler for NUM_COL column-periphery FIFOs sharing one 28-bit route output.

---
 rtl/readout_pkg.sv | 12 +
 rtl/rr_priority_pick.sv | 31 +++
 rtl/readout_rr_scheduler.sv | 121 ++++++++++++
 tb/tb_readout_rr_scheduler.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Types and constants shared by the readout scheduler and the column-periphery blocks.
package readout_pkg;

    localparam int unsigned DATA_W = 28;
    localparam logic [DATA_W-1:0] IDLE_WORD = 28'h0;

    typedef enum logic {
        ARB  = 1'b0,
        READ = 1'b1
    } rd_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority encoder: first requester at or after ptr, wrapping past the top column.
module rr_priority_pick #(
    parameter int unsigned NUM_COL = 4,
    parameter int unsigned COL_W   = (NUM_COL > 1) ? $clog2(NUM_COL) : 1
) (
    input  logic [NUM_COL-1:0] req,
    input  logic [COL_W-1:0]   ptr,
    output logic               found,
    output logic [COL_W-1:0]   idx,
    output logic [COL_W-1:0]   idx_next
);

    int j;

    // Walk from the far end back towards ptr so the closest requester is written last.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        idx_next = '0;
        j        = 0;
        for (int k = int'(NUM_COL) - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % int'(NUM_COL);
            if (req[COL_W'(j)]) begin
                found    = 1'b1;
                idx      = COL_W'(j);
                idx_next = COL_W'((j + 1) % int'(NUM_COL));
            end
        end
    end

endmodule

// File: rtl/readout_rr_scheduler.sv
// Round-robin readout scheduler: grants one column FIFO at a time, bursts up to BURST_MAX
// words onto the shared route output, then rotates priority to the next column.
module readout_rr_scheduler
    import readout_pkg::*;
#(
    parameter int unsigned       NUM_COL   = 4,
    parameter int unsigned       DATA_W    = readout_pkg::DATA_W,
    parameter int unsigned       BURST_MAX = 8,
    parameter logic [DATA_W-1:0] IDLE_WORD = readout_pkg::IDLE_WORD,
    localparam int unsigned      COL_W     = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int unsigned      CNT_W     = $clog2(BURST_MAX + 1)
) (
    input  logic                      clk_40MHz,
    input  logic                      rst_n,
    input  logic [NUM_COL-1:0]        col_en,
    input  logic [NUM_COL-1:0]        empty_merge,
    input  logic [NUM_COL*DATA_W-1:0] fifo_data,
    input  logic                      shakehands_proc,
    output logic [NUM_COL-1:0]        shake_hands_merge,
    output logic [DATA_W-1:0]         route_data_proc,
    output logic                      route_valid,
    output logic [COL_W-1:0]          grant_id,
    output logic                      busy
);

    rd_state_e           state, state_nxt;
    logic [COL_W-1:0]    ptr, ptr_nxt;
    logic [COL_W-1:0]    wrap_ptr, wrap_nxt;
    logic [COL_W-1:0]    grant_nxt;
    logic [CNT_W-1:0]    burst_cnt, cnt_nxt;
    logic [NUM_COL-1:0]  cand;
    logic                pick_found;
    logic [COL_W-1:0]    pick_idx, pick_idx_next;
    logic                rd;
    logic                rd_d1;
    logic [COL_W-1:0]    gsel_d1;
    logic [DATA_W-1:0]   col_word [NUM_COL];

    assign cand = col_en & ~empty_merge;

    rr_priority_pick #(
        .NUM_COL (NUM_COL),
        .COL_W   (COL_W)
    ) u_pick (
        .req      (cand),
        .ptr      (ptr),
        .found    (pick_found),
        .idx      (pick_idx),
        .idx_next (pick_idx_next)
    );

    for (genvar g = 0; g < int'(NUM_COL); g++) begin : g_col_word
        assign col_word[g] = fifo_data[g*DATA_W +: DATA_W];
    end

    // Read strobe is combinational so a FIFO that just went empty is never read again.
    always_comb begin
        rd = (state == READ) && cand[grant_id] && shakehands_proc
             && (burst_cnt < CNT_W'(BURST_MAX));
        shake_hands_merge = '0;
        if (rd) begin
            shake_hands_merge[grant_id] = 1'b1;
        end
    end

    // wrap_ptr holds grant_id+1 (mod NUM_COL), captured from the picker at grant time.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        wrap_nxt  = wrap_ptr;
        grant_nxt = grant_id;
        cnt_nxt   = burst_cnt;
        unique case (state)
            ARB: begin
                if (pick_found) begin
                    state_nxt = READ;
                    grant_nxt = pick_idx;
                    wrap_nxt  = pick_idx_next;
                    cnt_nxt   = '0;
                end
            end
            READ: begin
                if (rd) begin
                    cnt_nxt = burst_cnt + 1'b1;
                end
                if (!cand[grant_id] || (burst_cnt == CNT_W'(BURST_MAX))) begin
                    state_nxt = ARB;
                    ptr_nxt   = wrap_ptr;
                end
            end
        endcase
    end

    always_ff @(posedge clk_40MHz or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARB;
            ptr             <= '0;
            wrap_ptr        <= '0;
            grant_id        <= '0;
            burst_cnt       <= '0;
            rd_d1           <= 1'b0;
            gsel_d1         <= '0;
            route_valid     <= 1'b0;
            route_data_proc <= IDLE_WORD;
            busy            <= 1'b0;
        end else begin
            state           <= state_nxt;
            ptr             <= ptr_nxt;
            wrap_ptr        <= wrap_nxt;
            grant_id        <= grant_nxt;
            burst_cnt       <= cnt_nxt;
            rd_d1           <= rd;
            gsel_d1         <= grant_id;
            route_valid     <= rd_d1;
            route_data_proc <= rd_d1 ? col_word[gsel_d1] : IDLE_WORD;
            // Registered form of (state==READ) | rd_d1 | route_valid.
            busy            <= (state_nxt == READ) | rd | rd_d1;
        end
    end

endmodule

// File: tb/tb_readout_rr_scheduler.sv
// Directed bench for readout_rr_scheduler: behavioural column FIFOs with 1-cycle read latency.
module tb_readout_rr_scheduler;

    localparam int unsigned NC   = 4;
    localparam int unsigned DW   = 28;
    localparam int unsigned BM   = 4;
    localparam logic [DW-1:0] IDLE = 28'h0;

    logic               clk_40MHz = 1'b0;
    logic               rst_n;
    logic [NC-1:0]      col_en;
    logic [NC-1:0]      empty_merge;
    logic [NC*DW-1:0]   fifo_data;
    logic               shakehands_proc;
    logic [NC-1:0]      shake_hands_merge;
    logic [DW-1:0]      route_data_proc;
    logic               route_valid;
    logic [1:0]         grant_id;
    logic               busy;

    readout_rr_scheduler #(
        .NUM_COL   (NC),
        .DATA_W    (DW),
        .BURST_MAX (BM),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk_40MHz         (clk_40MHz),
        .rst_n             (rst_n),
        .col_en            (col_en),
        .empty_merge       (empty_merge),
        .fifo_data         (fifo_data),
        .shakehands_proc   (shakehands_proc),
        .shake_hands_merge (shake_hands_merge),
        .route_data_proc   (route_data_proc),
        .route_valid       (route_valid),
        .grant_id          (grant_id),
        .busy              (busy)
    );

    always #12 clk_40MHz = ~clk_40MHz;

    // Column FIFO model: word[11:8] of every loaded word carries its column number.
    logic [DW-1:0] mem [NC][64];
    int wp [NC];
    int rp [NC];
    int flush_gen;
    int flush_seen;
    int bad_rd;

    always @(posedge clk_40MHz) begin
        for (int i = 0; i < int'(NC); i++) begin
            if (flush_gen != flush_seen) begin
                rp[2'(i)] <= wp[2'(i)];
            end else if (shake_hands_merge[2'(i)]) begin
                if (rp[2'(i)] == wp[2'(i)]) begin
                    bad_rd <= bad_rd + 1;
                end else begin
                    fifo_data[i*DW +: DW] <= mem[2'(i)][6'(rp[2'(i)])];
                    rp[2'(i)] <= rp[2'(i)] + 1;
                end
            end
        end
        flush_seen <= flush_gen;
    end

    always_comb begin
        empty_merge = '0;
        for (int i = 0; i < int'(NC); i++) begin
            empty_merge[2'(i)] = (rp[2'(i)] == wp[2'(i)]);
        end
    end

    // Event logs, sampled on the falling edge.
    int cyc;
    int strb_col [512];
    int strb_cyc [512];
    int n_strb;
    logic [DW-1:0] out_dat [512];
    int out_cyc [512];
    int n_out;
    int bad_oh;

    always @(posedge clk_40MHz) cyc <= cyc + 1;

    always @(negedge clk_40MHz) begin
        if (shake_hands_merge != '0) begin
            if (!$onehot(shake_hands_merge)) bad_oh <= bad_oh + 1;
            for (int i = 0; i < int'(NC); i++) begin
                if (shake_hands_merge[2'(i)]) strb_col[9'(n_strb)] <= i;
            end
            strb_cyc[9'(n_strb)] <= cyc;
            n_strb <= n_strb + 1;
        end
        if (route_valid) begin
            out_dat[9'(n_out)] <= route_data_proc;
            out_cyc[9'(n_out)] <= cyc;
            n_out <= n_out + 1;
        end
    end

    int n_chk;
    int n_err;
    logic [DW-1:0] exp_w [32];
    int exp_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_40MHz);
    endtask

    task automatic load(input int col, input int n, input logic [DW-1:0] base);
        for (int k = 0; k < n; k++) begin
            mem[2'(col)][6'(wp[2'(col)])] = base + DW'(k);
            wp[2'(col)] = wp[2'(col)] + 1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush_gen++;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic expect_run(input logic [DW-1:0] base, input int n);
        for (int k = 0; k < n; k++) begin
            exp_w[5'(exp_n)] = base + DW'(k);
            exp_n++;
        end
    endtask

    task automatic wait_strobes(input string tag, input int base, input int n);
        int t = 0;
        do begin
            @(posedge clk_40MHz);
            #1;
            t++;
        end while ((n_strb - base < n) && (t < 40));
        check(tag, 32'(n_strb - base >= n), 32'd1);
    endtask

    task automatic check_stream(input string tag, input int s, input int o);
        logic [DW-1:0] w;
        check($sformatf("%s_nstrb", tag), n_strb - s, exp_n);
        check($sformatf("%s_nout", tag), n_out - o, exp_n);
        for (int k = 0; k < exp_n; k++) begin
            w = exp_w[5'(k)];
            check($sformatf("%s_word%0d", tag, k), 32'(out_dat[9'(o + k)]), 32'(w));
            check($sformatf("%s_col%0d", tag, k), strb_col[9'(s + k)], 32'(w[11:8]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, o, s2, c0, c2, gap_ok;
        rst_n = 1'b0;
        col_en = 4'hF;
        shakehands_proc = 1'b1;
        tick(2);
        check("rst_strobe", 32'(shake_hands_merge), 32'h0);
        check("rst_valid", 32'(route_valid), 32'h0);
        check("rst_data", 32'(route_data_proc), 32'(IDLE));
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_grant", 32'(grant_id), 32'h0);
        rst_n = 1'b1;
        tick(1);

        // 1) Single column, three words, latency and pointer advance.
        s = n_strb; o = n_out; exp_n = 0;
        load(1, 3, 28'h10A);
        expect_run(28'h10A, 3);
        tick(12);
        check_stream("t1", s, o);
        check("t1_consec", strb_cyc[9'(s + 2)] - strb_cyc[9'(s)], 2);
        for (int k = 0; k < 3; k++)
            check($sformatf("t1_lat%0d", k), out_cyc[9'(o + k)] - strb_cyc[9'(s + k)], 2);
        check("t1_ptr", 32'(dut.ptr), 32'd2);
        check("t1_state", 32'(dut.state), 32'(readout_pkg::ARB));
        check("t1_busy", 32'(busy), 32'h0);

        // 2) Two heavy columns alternate in bursts of BURST_MAX.
        do_reset();
        s = n_strb; o = n_out; exp_n = 0;
        load(0, 10, 28'h000);
        load(2, 10, 28'h200);
        expect_run(28'h000, 4); expect_run(28'h200, 4);
        expect_run(28'h004, 4); expect_run(28'h204, 4);
        expect_run(28'h008, 2); expect_run(28'h208, 2);
        tick(70);
        check_stream("t2", s, o);
        gap_ok = 1;
        for (int k = s + 1; k < n_strb; k++)
            if (strb_col[9'(k)] != strb_col[9'(k - 1)] && strb_cyc[9'(k)] - strb_cyc[9'(k - 1)] < 2)
                gap_ok = 0;
        check("t2_arb_gap", 32'(gap_ok), 32'd1);

        // 3) Pointer wraps from column 3 back to column 0.
        do_reset();
        s = n_strb; o = n_out; exp_n = 0;
        load(3, 6, 28'h300);
        wait_strobes("t3_wait", s, 2);
        load(0, 2, 28'h010);
        expect_run(28'h300, 4); expect_run(28'h010, 2); expect_run(28'h304, 2);
        tick(40);
        check_stream("t3", s, o);

        // 4) Downstream stall mid-burst at burst_cnt=2.
        do_reset();
        s = n_strb; o = n_out; exp_n = 0;
        load(1, 6, 28'h100);
        expect_run(28'h100, 6);
        wait_strobes("t4_wait", s, 2);
        shakehands_proc = 1'b0;
        s2 = n_strb;
        repeat (5) @(posedge clk_40MHz);
        #1;
        check("t4_no_strobe", n_strb - s2, 0);
        check("t4_inflight", n_out - o, 2);
        check("t4_cnt_held", 32'(dut.burst_cnt), 32'd2);
        check("t4_grant", 32'(grant_id), 32'd1);
        check("t4_busy", 32'(busy), 32'd1);
        shakehands_proc = 1'b1;
        tick(30);
        check_stream("t4", s, o);
        check("t4_stall_len", 32'(strb_cyc[9'(s + 2)] - strb_cyc[9'(s + 1)] >= 6), 32'd1);
        check("t4_resume", strb_cyc[9'(s + 3)] - strb_cyc[9'(s + 2)], 1);
        check("t4_rotate", 32'(strb_cyc[9'(s + 4)] - strb_cyc[9'(s + 3)] > 1), 32'd1);

        // 5) Column enable dropped mid-burst.
        do_reset();
        s = n_strb; o = n_out;
        load(2, 8, 28'h200);
        wait_strobes("t5_wait", s, 1);
        col_en = 4'b1011;
        s2 = n_strb;
        load(0, 2, 28'h000);
        tick(40);
        c0 = 0; c2 = 0;
        for (int k = s2; k < n_strb; k++) begin
            if (strb_col[9'(k)] == 2) c2++;
            if (strb_col[9'(k)] == 0) c0++;
        end
        check("t5_col2_after", 32'(c2 <= 1), 32'd1);
        check("t5_col0_reads", c0, 2);
        check("t5_delivered", n_out - o, n_strb - s);
        check("t5_grant", 32'(grant_id), 32'd0);
        col_en = 4'hF;

        // 6) Reset during a burst, then arbitration restarts from column 0.
        do_reset();
        load(2, 2, 28'h200);
        tick(12);
        s = n_strb;
        load(2, 8, 28'h210);
        wait_strobes("t6_wait", s, 2);
        rst_n = 1'b0;
        #1;
        check("t6_strobe", 32'(shake_hands_merge), 32'h0);
        check("t6_valid", 32'(route_valid), 32'h0);
        check("t6_data", 32'(route_data_proc), 32'(IDLE));
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_ptr", 32'(dut.ptr), 32'h0);
        flush_gen++;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        s = n_strb; o = n_out; exp_n = 0;
        load(0, 1, 28'h000);
        load(3, 1, 28'h300);
        expect_run(28'h000, 1); expect_run(28'h300, 1);
        tick(20);
        check_stream("t6", s, o);

        check("read_when_empty", bad_rd, 0);
        check("strobe_onehot", bad_oh, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
